// File: rtl/enemy_pool.sv
// rtl/enemy_pool.sv - enemy slot pool: spawn allocation, multi-hit health, dying timer, descent, render
module enemy_pool #(
  parameter int NPOOL       = 4,
  parameter int HP          = 2,
  parameter int HALF_D      = 16,
  parameter int START_Y     = 48,
  parameter int STEP_Y      = 10,
  parameter int BOTTOM_Y    = 440,
  parameter int DYING_TICKS = 24_999_999,
  parameter int FLICK_BIT   = 22
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [9:0]                   x,
  input  logic [8:0]                   y,
  input  logic [9:0]                   shoot_x,
  input  logic [8:0]                   shoot_y,
  input  logic                         shot,
  input  logic                         shot_blocked,
  input  logic                         spawn,
  input  logic [9:0]                   spawn_x,
  input  logic                         move,
  output logic                         render,
  output logic                         killed,
  output logic [$clog2(NPOOL)-1:0]     kill_idx,
  output logic                         escaped,
  output logic                         spawned,
  output logic                         full,
  output logic [NPOOL-1:0]             alive_mask,
  output logic [$clog2(NPOOL+1)-1:0]   alive_cnt
);

  localparam int IW   = $clog2(NPOOL);
  localparam int NW   = $clog2(NPOOL + 1);
  localparam int HW   = $clog2(HP + 1);
  localparam int CW0  = $clog2(DYING_TICKS + 1);
  localparam int CW   = (CW0 > FLICK_BIT) ? CW0 : FLICK_BIT + 1;

  typedef enum logic [1:0] {DEAD = 2'd0, ALIVE = 2'd1, DYING = 2'd2} slot_state_t;

  slot_state_t     st_q  [NPOOL];
  slot_state_t     st_d  [NPOOL];
  logic [9:0]      cx_q  [NPOOL];
  logic [9:0]      cx_d  [NPOOL];
  logic [8:0]      cy_q  [NPOOL];
  logic [8:0]      cy_d  [NPOOL];
  logic [HW-1:0]   hp_q  [NPOOL];
  logic [HW-1:0]   hp_d  [NPOOL];
  logic [CW-1:0]   cnt_q [NPOOL];
  logic [CW-1:0]   cnt_d [NPOOL];
  logic [8:0]      moved_y [NPOOL];
  logic            render_q;

  logic            alloc_found;
  logic [IW-1:0]   alloc_idx;
  logic            hit_found;
  logic [IW-1:0]   hit_idx;
  logic            do_alloc;
  logic            do_hit;
  logic            do_kill;
  logic [NPOOL-1:0] esc_vec;
  logic            vis_any;

  // Half-open box test; the low edge is checked as p+HALF_D >= c so nothing wraps below 0.
  function automatic logic in_box(input logic [9:0] px, input logic [8:0] py,
                                  input logic [9:0] cx, input logic [8:0] cy);
    logic hx;
    logic hy;
    hx = (({1'b0, px} + 11'(HALF_D)) >= {1'b0, cx}) && ({1'b0, px} < ({1'b0, cx} + 11'(HALF_D)));
    hy = (({1'b0, py} + 10'(HALF_D)) >= {1'b0, cy}) && ({1'b0, py} < ({1'b0, cy} + 10'(HALF_D)));
    return hx && hy;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPOOL; i++) begin
        st_q[i]  <= DEAD;
        cx_q[i]  <= '0;
        cy_q[i]  <= 9'(START_Y);
        hp_q[i]  <= HW'(HP);
        cnt_q[i] <= '0;
      end
      render_q <= 1'b0;
    end else begin
      for (int i = 0; i < NPOOL; i++) begin
        st_q[i]  <= st_d[i];
        cx_q[i]  <= cx_d[i];
        cy_q[i]  <= cy_d[i];
        hp_q[i]  <= hp_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      render_q <= vis_any;
    end
  end

  // Slot selection: allocation prefers DEAD over DYING, the shot goes to the lowest hit slot.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    hit_found   = 1'b0;
    hit_idx     = '0;
    vis_any     = 1'b0;
    for (int i = 0; i < NPOOL; i++) begin
      if (!alloc_found && st_q[i] == DEAD) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NPOOL; i++) begin
      if (!alloc_found && st_q[i] == DYING) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
    for (int i = 0; i < NPOOL; i++) begin
      if (!hit_found && st_q[i] == ALIVE && in_box(shoot_x, shoot_y, cx_q[i], cy_q[i])) begin
        hit_found = 1'b1;
        hit_idx   = IW'(i);
      end
    end
    do_alloc = spawn && alloc_found;
    do_hit   = shot && !shot_blocked && hit_found;
    do_kill  = do_hit && (hp_q[hit_idx] == HW'(1));
    for (int i = 0; i < NPOOL; i++) begin
      moved_y[i] = 9'(cy_q[i] + 9'(STEP_Y));
      esc_vec[i] = move && st_q[i] == ALIVE && (moved_y[i] >= 9'(BOTTOM_Y))
                   && !(do_kill && hit_idx == IW'(i));
      if (in_box(x, y, cx_q[i], cy_q[i]) &&
          (st_q[i] == ALIVE || (st_q[i] == DYING && !cnt_q[i][FLICK_BIT])))
        vis_any = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NPOOL; i++) begin
      st_d[i]  = st_q[i];
      cx_d[i]  = cx_q[i];
      cy_d[i]  = cy_q[i];
      hp_d[i]  = hp_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        ALIVE: begin
          if (do_kill && hit_idx == IW'(i)) begin
            st_d[i]  = DYING;
            hp_d[i]  = HW'(HP);
            cnt_d[i] = '0;
          end else begin
            if (do_hit && hit_idx == IW'(i))
              hp_d[i] = hp_q[i] - HW'(1);
            if (move)
              cy_d[i] = moved_y[i];
            if (esc_vec[i])
              st_d[i] = DEAD;
          end
        end
        DYING: begin
          if (cnt_q[i] == CW'(DYING_TICKS))
            st_d[i] = DEAD;
          else
            cnt_d[i] = cnt_q[i] + CW'(1);
        end
        default: ;
      endcase
      if (do_alloc && alloc_idx == IW'(i)) begin
        st_d[i]  = ALIVE;
        cx_d[i]  = spawn_x;
        cy_d[i]  = 9'(START_Y);
        hp_d[i]  = HW'(HP);
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < NPOOL; i++) begin
      alive_mask[i] = (st_q[i] == ALIVE);
      alive_cnt     = alive_cnt + NW'(alive_mask[i]);
    end
    full     = &alive_mask;
    spawned  = !reset && do_alloc;
    killed   = !reset && do_kill;
    kill_idx = killed ? hit_idx : '0;
    escaped  = !reset && (|esc_vec);
    render   = render_q;
  end

endmodule
